// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: XLEN, the canonical NOP, fetch-buffer entry and
// the fetch-stage state encoding.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
    logic            err;
  } if_entry_t;

  typedef enum logic [1:0] {
    IF_BOOT  = 2'd0,
    IF_RUN   = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Small instruction buffer between the memory response channel and the
// decode-facing output register. Read data is presented combinationally.
module ifetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  if_entry_t     wr_entry,
  output if_entry_t     rd_entry,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  if_entry_t     mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push && !clear) mem_reg[wr_ptr_reg] <= wr_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_entry = mem_reg[rd_ptr_reg];
  assign count    = count_reg;
  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: credit-limited sequential requests, in-order response
// buffering, and a flopped instruction/PC slot for decode with flush draining.
module ifetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_v_o,
  input  logic            imem_req_rdy_i,
  output logic [XLEN-1:0] imem_adr_o,
  input  logic            imem_rsp_v_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  input  logic            stall_i,
  input  logic            flush_v_i,
  input  logic [XLEN-1:0] flush_pc_i,
  output logic            instr_v_q_o,
  output logic [XLEN-1:0] instr_q_o,
  output logic [XLEN-1:0] pc0_q_o,
  output logic            instr_fault_q_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  if_state_e       state_reg, state_next;
  logic [XLEN-1:0] fetch_pc_reg, rsp_pc_reg;
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            fifo_full, fifo_empty;
  if_entry_t       fifo_wr, fifo_rd;
  logic            accept, dropping, push, pop;
  logic [XLEN-1:0] flush_pc_aligned;

  assign flush_pc_aligned = flush_pc_i & ALIGN_MASK;
  assign credit_used      = {1'b0, outstanding_reg} + {1'b0, fifo_count};

  assign imem_req_v_o = (state_reg == IF_RUN) && !flush_v_i
                        && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_adr_o   = fetch_pc_reg & ALIGN_MASK;
  assign accept       = imem_req_v_o && imem_req_rdy_i;

  // Responses to requests issued before a flush are consumed but never buffered.
  assign dropping = (drop_cnt_reg != '0);
  assign push     = imem_rsp_v_i && !dropping && !flush_v_i;
  assign pop      = !flush_v_i && !stall_i && !fifo_empty;
  assign fifo_wr  = '{data: imem_rsp_data_i, pc: rsp_pc_reg, err: imem_rsp_err_i};

  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .clear    (flush_v_i),
    .wr_entry (fifo_wr),
    .rd_entry (fifo_rd),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    outstanding_next = outstanding_reg;
    if (accept && !imem_rsp_v_i)      outstanding_next = outstanding_reg + CW'(1);
    else if (!accept && imem_rsp_v_i) outstanding_next = outstanding_reg - CW'(1);

    drop_cnt_next = drop_cnt_reg;
    if (flush_v_i)                     drop_cnt_next = outstanding_next;
    else if (imem_rsp_v_i && dropping) drop_cnt_next = drop_cnt_reg - CW'(1);

    state_next = state_reg;
    case (state_reg)
      IF_BOOT:  state_next = IF_RUN;
      IF_RUN:   if (flush_v_i && outstanding_next != '0) state_next = IF_DRAIN;
      IF_DRAIN: if (drop_cnt_next == '0) state_next = IF_RUN;
      default:  state_next = IF_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IF_BOOT;
      fetch_pc_reg    <= RESET_PC & ALIGN_MASK;
      rsp_pc_reg      <= RESET_PC & ALIGN_MASK;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      instr_v_q_o     <= 1'b0;
      instr_q_o       <= NOP_INSTR;
      pc0_q_o         <= RESET_PC;
      instr_fault_q_o <= 1'b0;
    end else begin
      state_reg       <= state_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;

      if (flush_v_i) begin
        fetch_pc_reg <= flush_pc_aligned;
        rsp_pc_reg   <= flush_pc_aligned;
      end else begin
        if (accept) fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
        if (push)   rsp_pc_reg   <= rsp_pc_reg + XLEN'(4);
      end

      // A flush forces a bubble even when decode is stalled.
      if (flush_v_i || (!stall_i && !pop)) begin
        instr_v_q_o     <= 1'b0;
        instr_q_o       <= NOP_INSTR;
        instr_fault_q_o <= 1'b0;
      end else if (pop) begin
        instr_v_q_o     <= 1'b1;
        instr_q_o       <= fifo_rd.err ? NOP_INSTR : fifo_rd.data;
        pc0_q_o         <= fifo_rd.pc;
        instr_fault_q_o <= fifo_rd.err;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
                                  !(push && fifo_full && !pop))
    else $error("ifetch: instruction buffer overflow");

endmodule

// File: tb/tb_ifetch.sv
// Randomised bench for ifetch: an in-order latency memory plus a queue-based
// model of the fetch stream predicts every request and every decode slot.
module tb_ifetch;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_v_o, imem_req_rdy_i, imem_rsp_v_i, imem_rsp_err_i;
  logic [31:0] imem_adr_o, imem_rsp_data_i, flush_pc_i;
  logic        stall_i, flush_v_i;
  logic        instr_v_q_o, instr_fault_q_o;
  logic [31:0] instr_q_o, pc0_q_o;

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_v_o(imem_req_v_o), .imem_req_rdy_i(imem_req_rdy_i), .imem_adr_o(imem_adr_o),
    .imem_rsp_v_i(imem_rsp_v_i), .imem_rsp_data_i(imem_rsp_data_i), .imem_rsp_err_i(imem_rsp_err_i),
    .stall_i(stall_i), .flush_v_i(flush_v_i), .flush_pc_i(flush_pc_i),
    .instr_v_q_o(instr_v_q_o), .instr_q_o(instr_q_o), .pc0_q_o(pc0_q_o),
    .instr_fault_q_o(instr_fault_q_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a == 32'h8000_0008) || (a[8:2] == 7'h55) || (a[8:2] == 7'h2A);
  endfunction

  // Memory model: accepted addresses with their response due cycles.
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          last_due = 0;
  // Fetch model: responses that have reached the buffer, in PC order.
  logic [31:0] buf_pc_q[$];
  logic [31:0] exp_fetch_pc = RESET_PC;
  int          outstanding = 0;
  int          stale = 0;
  bit          booted = 0;
  logic        exp_v = 1'b0, exp_fault = 1'b0;
  logic [31:0] exp_instr = NOP_INSTR, exp_pc = RESET_PC;
  int          cyc = 0;

  int          valid_cnt = 0;
  bit          watch_flush = 0, got_after_flush = 0;
  logic [31:0] first_pc_after_flush = '0;
  bit          slot_seen = 0;
  logic        slot_fault = 1'b0;
  logic [31:0] slot_instr = '0;

  task automatic do_cycle(input bit rdy, input bit stall, input bit flush,
                          input logic [31:0] fpc, input int lat);
    logic [31:0] rsp_addr;
    logic [31:0] p;
    bit          exp_req, accept;
    int          due;
    @(negedge clk);
    imem_req_rdy_i = rdy;
    stall_i        = stall;
    flush_v_i      = flush;
    flush_pc_i     = flush ? fpc : $urandom();
    rsp_addr       = '0;
    if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      rsp_addr = mem_addr_q.pop_front();
      void'(mem_due_q.pop_front());
      imem_rsp_v_i    = 1'b1;
      imem_rsp_data_i = mem_data(rsp_addr);
      imem_rsp_err_i  = mem_err(rsp_addr);
    end else begin
      imem_rsp_v_i    = 1'b0;
      imem_rsp_data_i = $urandom();
      imem_rsp_err_i  = 1'($urandom_range(0, 1));
    end
    #2;
    // Decode slot loaded at the previous edge.
    check_val("instr_v", 32'(instr_v_q_o), 32'(exp_v));
    check_val("instr", instr_q_o, exp_instr);
    check_val("pc0", pc0_q_o, exp_pc);
    check_val("fault", 32'(instr_fault_q_o), 32'(exp_fault));
    if (instr_v_q_o === 1'b1) begin
      valid_cnt++;
      $display("OUT cyc=%0d pc=%h instr=%h fault=%0d", cyc, pc0_q_o, instr_q_o, instr_fault_q_o);
      if (watch_flush && !got_after_flush) begin
        got_after_flush = 1;
        first_pc_after_flush = pc0_q_o;
      end
      if (pc0_q_o == 32'h8000_0008 && !slot_seen) begin
        slot_seen = 1; slot_fault = instr_fault_q_o; slot_instr = instr_q_o;
      end
    end
    // Request channel: credit is outstanding requests plus buffered entries.
    exp_req = booted && stale == 0 && !flush && (outstanding + buf_pc_q.size() < 2);
    check_val("req_v", 32'(imem_req_v_o), 32'(exp_req));
    if (imem_req_v_o === 1'b1) check_val("req_adr", imem_adr_o, exp_fetch_pc);
    accept = (imem_req_v_o === 1'b1) && rdy;
    // What the next edge loads; the pop decision sees the buffer before this push.
    if (flush) begin
      exp_v = 1'b0; exp_instr = NOP_INSTR; exp_fault = 1'b0;
      buf_pc_q.delete();
    end else if (!stall) begin
      if (buf_pc_q.size() > 0) begin
        p = buf_pc_q.pop_front();
        exp_v = 1'b1; exp_pc = p; exp_fault = mem_err(p);
        exp_instr = exp_fault ? NOP_INSTR : mem_data(p);
      end else begin
        exp_v = 1'b0; exp_instr = NOP_INSTR; exp_fault = 1'b0;
      end
    end
    if (imem_rsp_v_i) begin
      outstanding--;
      if (stale > 0) stale--;
      else if (!flush) buf_pc_q.push_back(rsp_addr);
    end
    if (accept) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_addr_q.push_back(imem_adr_o);
      mem_due_q.push_back(due);
      exp_fetch_pc = exp_fetch_pc + 32'd4;
      outstanding++;
    end
    check_val("credit_cap", 32'(outstanding + buf_pc_q.size() <= 2), 32'd1);
    if (flush) begin
      stale = outstanding;
      exp_fetch_pc = fpc & ~32'd3;
      watch_flush = 1; got_after_flush = 0;
    end
    cyc++;
  endtask

  initial begin
    int start_cnt;
    bit reached;
    imem_req_rdy_i = 0; imem_rsp_v_i = 0; imem_rsp_data_i = '0; imem_rsp_err_i = 0;
    stall_i = 0; flush_v_i = 0; flush_pc_i = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    #2;
    check_val("rst_instr_v", 32'(instr_v_q_o), 32'd0);
    check_val("rst_instr", instr_q_o, NOP_INSTR);
    check_val("rst_pc0", pc0_q_o, RESET_PC);
    check_val("rst_fault", 32'(instr_fault_q_o), 32'd0);
    check_val("rst_req_v", 32'(imem_req_v_o), 32'd0);
    @(negedge clk);
    imem_req_rdy_i = 1;
    reset_n = 1'b1;
    #2;
    check_val("boot_req_v", 32'(imem_req_v_o), 32'd0);
    booted = 1;

    // Zero-wait memory streaming from RESET_PC (fault on 0x8000_0008).
    start_cnt = valid_cnt;
    repeat (30) do_cycle(1, 0, 0, '0, 1);
    check_val("stream_count", 32'(valid_cnt - start_cnt >= 14), 32'd1);
    check_val("fault_slot_seen", 32'(slot_seen), 32'd1);
    check_val("fault_slot_fault", 32'(slot_fault), 32'd1);
    check_val("fault_slot_instr", slot_instr, NOP_INSTR);

    // Memory not ready, then decode stall, then resume.
    repeat (5) do_cycle(0, 0, 0, '0, 1);
    repeat (6) do_cycle(1, 0, 0, '0, 1);
    repeat (4) do_cycle(1, 1, 0, '0, 1);
    repeat (10) do_cycle(1, 0, 0, '0, 1);

    // Flush to 0x102 with two requests outstanding.
    reached = 0;
    for (int i = 0; i < 10 && !reached; i++) begin
      if (outstanding == 2) reached = 1;
      else do_cycle(1, 0, 0, '0, 4);
    end
    check_val("flush1_two_outstanding", 32'(reached), 32'd1);
    do_cycle(1, 0, 1, 32'h0000_0102, 4);
    check_val("flush1_drop_cnt", 32'(stale), 32'd2);
    repeat (20) do_cycle(1, 0, 0, '0, 1);
    check_val("flush1_first_pc", first_pc_after_flush, 32'h0000_0100);

    // Flush to 0x300, then re-flush to 0x200 with one stale response left.
    reached = 0;
    for (int i = 0; i < 10 && !reached; i++) begin
      if (outstanding == 2) reached = 1;
      else do_cycle(1, 0, 0, '0, (outstanding == 0) ? 3 : 7);
    end
    check_val("flush2_two_outstanding", 32'(reached), 32'd1);
    do_cycle(1, 0, 1, 32'h0000_0300, 1);
    reached = 0;
    for (int i = 0; i < 10 && !reached; i++) begin
      if (stale == 1) reached = 1;
      else do_cycle(1, 0, 0, '0, 1);
    end
    check_val("flush2_one_left", 32'(reached), 32'd1);
    do_cycle(1, 0, 1, 32'h0000_0200, 1);
    check_val("flush2_reload", 32'(stale), 32'd1);
    repeat (20) do_cycle(1, 0, 0, '0, 1);
    check_val("flush2_first_pc", first_pc_after_flush, 32'h0000_0200);

    // Random mix of ready, stall, latency and flushes.
    for (int i = 0; i < 300; i++) begin
      do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 31) == 0, $urandom(), $urandom_range(1, 3));
    end
    start_cnt = valid_cnt;
    repeat (20) do_cycle(1, 0, 0, '0, 1);
    check_val("final_stream_count", 32'(valid_cnt - start_cnt >= 8), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
